// File: rtl/spike_pkg.sv
// Shared definitions for the spike scheduler.
//   - spk_state_e : phase FSM states
//   - spk_event_t : event record layout {ch, ts} at the default widths
//   - *Default    : parameter defaults used by spike_scheduler
package spike_pkg;

  localparam int unsigned NumChDefault     = 8;
  localparam int unsigned IntCyclesDefault = 16;
  localparam int unsigned CmpCyclesDefault = 4;
  localparam int unsigned FifoDepthDefault = 8;
  localparam int unsigned TsWDefault       = 16;
  localparam int unsigned ChWDefault       = $clog2(NumChDefault);

  typedef enum logic [1:0] {
    StIdle,
    StIntegrate,
    StCompare
  } spk_state_e;

  // Event layout. The FIFO stores the same {ch, ts} packing at the widths the
  // scheduler is configured with; ts is dropped when timestamps are disabled.
  typedef struct packed {
    logic [ChWDefault-1:0] ch;
    logic [TsWDefault-1:0] ts;
  } spk_event_t;

endpackage

// File: rtl/spike_fifo.sv
// Synchronous first-word-fall-through event FIFO.
// The head entry is presented directly from the storage flops, so data_o is
// valid in the same cycle that empty_o drops. data_o reads 0 while empty.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   push_i, data_i  : write request and data (ignored when full unless popping)
//   pop_i           : consume the head entry (ignored when empty)
//   data_o          : head entry
//   full_o, empty_o : occupancy flags
// A push and a pop in the same cycle both take effect, even when full.
module spike_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             pop_i,
  output logic [Width-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AddrW = $clog2(Depth);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW:0]   wr_ptr_q, wr_ptr_d;
  logic [AddrW:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  always_comb begin
    empty_o = (wr_ptr_q == rd_ptr_q);
    // Extra pointer bit distinguishes full from empty when indices match.
    full_o  = (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]) &&
              (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
    do_pop  = pop_i & ~empty_o;
    do_push = push_i & (~full_o | do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    data_o   = empty_o ? '0 : mem_q[rd_ptr_q[AddrW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: nothing is visible while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/spike_scheduler.sv
// Spike scheduler: drives the shared spikifier phase clock, captures spikes
// from asynchronous spikifier outputs and queues them as channel events.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   enable     : run integrate/compare frames while high
//   spk_clk    : phase clock (0 = integrate, 1 = compare/reset/idle), from a flop
//   q_in       : spikifier outputs, asynchronous to clk
//   ev_valid, ev_ready, ev_ch : event stream (valid/ready handshake)
//   ev_ts      : frame number of the event (only with SPK_TIMESTAMP_EN)
//   overflow   : sticky flag, a spike arrived while its channel was still pending
//   ovf_clr    : clears overflow (a same-cycle overflow event wins)
//   busy       : FSM not idle or events queued
// Build option: define SPK_TIMESTAMP_EN to store the frame count with each
// event and present it on ev_ts.
module spike_scheduler
  import spike_pkg::*;
#(
  parameter int unsigned NUM_CH     = NumChDefault,
  parameter int unsigned INT_CYCLES = IntCyclesDefault,
  parameter int unsigned CMP_CYCLES = CmpCyclesDefault,
  parameter int unsigned FIFO_DEPTH = FifoDepthDefault,
  parameter int unsigned TS_W       = TsWDefault
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable,
  output logic                      spk_clk,
  input  logic [NUM_CH-1:0]         q_in,
  output logic                      ev_valid,
  input  logic                      ev_ready,
  output logic [$clog2(NUM_CH)-1:0] ev_ch,
`ifdef SPK_TIMESTAMP_EN
  output logic [TS_W-1:0]           ev_ts,
`endif
  output logic                      overflow,
  input  logic                      ovf_clr,
  output logic                      busy
);

  localparam int unsigned ChW      = $clog2(NUM_CH);
  localparam int unsigned PhaseMax = (INT_CYCLES > CMP_CYCLES) ? INT_CYCLES : CMP_CYCLES;
  localparam int unsigned CntW     = $clog2(PhaseMax);
`ifdef SPK_TIMESTAMP_EN
  localparam int unsigned EvW      = ChW + TS_W;
`else
  localparam int unsigned EvW      = ChW;
`endif

  localparam logic [CntW-1:0] IntLast = CntW'(INT_CYCLES - 1);
  localparam logic [CntW-1:0] CmpLast = CntW'(CMP_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Phase FSM
  // ---------------------------------------------------------------------------
  spk_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            spk_clk_q, spk_clk_d;
  logic            frame_inc;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    frame_inc = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable) state_d = StIntegrate;
      end
      // enable is ignored here: a started frame always runs to completion.
      StIntegrate: begin
        if (cnt_q == IntLast) begin
          state_d   = StCompare;
          cnt_d     = '0;
          frame_inc = 1'b1;
        end
      end
      StCompare: begin
        if (cnt_q == CmpLast) begin
          state_d = enable ? StIntegrate : StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    spk_clk_d = (state_d != StIntegrate);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      spk_clk_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      spk_clk_q <= spk_clk_d;
    end
  end

  assign spk_clk = spk_clk_q;

`ifdef SPK_TIMESTAMP_EN
  logic [TS_W-1:0] frame_q, frame_d;

  always_comb begin
    frame_d = frame_inc ? frame_q + 1'b1 : frame_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_q <= '0;
    else        frame_q <= frame_d;
  end
`endif

  // ---------------------------------------------------------------------------
  // Spike capture: 2-flop synchronizer, then a registered rise detector.
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] sync1_q, sync2_q, sync3_q;
  logic [NUM_CH-1:0] rise_q, rise_d;

  always_comb begin
    rise_d = sync2_q & ~sync3_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      sync3_q <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= q_in;
      sync2_q <= sync1_q;
      sync3_q <= sync2_q;
      rise_q  <= rise_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbiter and pending bits
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0] pending_q, pending_d;
  logic [NUM_CH-1:0] grant;
  logic [ChW-1:0]    ptr_q, ptr_d;
  logic [ChW-1:0]    grant_ch;
  logic              grant_vld;
  logic              overflow_q, overflow_d;
  logic              ovf_evt;
  logic              fifo_full, fifo_empty, pop, can_push;
  logic [EvW-1:0]    push_data, head_data;
  int unsigned       idx;
  logic [ChW-1:0]    idx_ch;

  always_comb begin
    pop      = ev_valid & ev_ready;
    // A slot freed by this cycle's pop is usable by this cycle's push.
    can_push = ~fifo_full | pop;

    grant_vld = 1'b0;
    grant_ch  = '0;
    idx       = 0;
    idx_ch    = '0;
    // Search starts one past the last granted channel and wraps.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      idx    = (32'(ptr_q) + 32'd1 + k) % NUM_CH;
      idx_ch = ChW'(idx);
      if (!grant_vld && pending_q[idx_ch]) begin
        grant_vld = 1'b1;
        grant_ch  = idx_ch;
      end
    end
    // While full, nothing is granted so pending bits are simply held.
    if (!can_push) grant_vld = 1'b0;

    grant = grant_vld ? (NUM_CH'(1) << grant_ch) : '0;
    ptr_d = grant_vld ? grant_ch : ptr_q;

    // A fresh rise on a channel being granted this cycle re-arms it cleanly.
    ovf_evt    = |(rise_q & pending_q & ~grant);
    pending_d  = (pending_q & ~grant) | rise_q;
    overflow_d = (overflow_q & ~ovf_clr) | ovf_evt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q  <= '0;
      ptr_q      <= ChW'(NUM_CH - 1);
      overflow_q <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      ptr_q      <= ptr_d;
      overflow_q <= overflow_d;
    end
  end

  assign overflow = overflow_q;

  // ---------------------------------------------------------------------------
  // Event FIFO
  // ---------------------------------------------------------------------------
`ifdef SPK_TIMESTAMP_EN
  assign push_data = {grant_ch, frame_q};
  assign ev_ch     = head_data[EvW-1 -: ChW];
  assign ev_ts     = head_data[TS_W-1:0];
`else
  assign push_data = grant_ch;
  assign ev_ch     = head_data;
`endif

  spike_fifo #(
    .Width (EvW),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (grant_vld),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (head_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign ev_valid = ~fifo_empty;
  assign busy     = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_spike_scheduler.sv
// Bench for spike_scheduler: directed stimulus; expected channel events go
// into a queue that a negedge monitor pops on every handshake.
module tb_spike_scheduler;

  localparam int unsigned NumCh = 16;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        spk_clk;
  logic [15:0] q_in;
  logic        ev_valid;
  logic        ev_ready;
  logic [3:0]  ev_ch;
`ifdef SPK_TIMESTAMP_EN
  logic [15:0] ev_ts;
`endif
  logic        overflow;
  logic        ovf_clr;
  logic        busy;

  int total;
  int bad;

  logic [3:0] exp_q [$];
  logic       stall_q;
  logic [3:0] held_ch;

  spike_scheduler #(
    .NUM_CH     (NumCh),
    .INT_CYCLES (16),
    .CMP_CYCLES (4),
    .FIFO_DEPTH (8),
    .TS_W       (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .spk_clk  (spk_clk),
    .q_in     (q_in),
    .ev_valid (ev_valid),
    .ev_ready (ev_ready),
    .ev_ch    (ev_ch),
`ifdef SPK_TIMESTAMP_EN
    .ev_ts    (ev_ts),
`endif
    .overflow (overflow),
    .ovf_clr  (ovf_clr),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: a transfer happens on the next rising edge whenever valid & ready
  // is seen here; also checks the head stays put while stalled.
  always @(negedge clk) begin
    if (!rst_n) begin
      stall_q = 1'b0;
    end else begin
      if (stall_q && ev_valid) check("hold_ch", 32'(ev_ch), 32'(held_ch));
      if (ev_valid && ev_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_ev: got ch %0d expected no event", ev_ch);
        end else begin
          check("ev_ch", 32'(ev_ch), 32'(exp_q.pop_front()));
        end
      end
      stall_q = ev_valid && !ev_ready;
      held_ch = ev_ch;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic exp_low;
    total = 0;
    bad   = 0;
    rst_n = 1'b0; enable = 1'b0; q_in = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (2) tick();
    check("rst_spk_clk", 32'(spk_clk), 1);
    check("rst_valid", 32'(ev_valid), 0);
    check("rst_ch", 32'(ev_ch), 0);
    check("rst_ovf", 32'(overflow), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Single spike on channel 3: input changes just after edge t.
    q_in = 16'h0008;
    repeat (4) tick();
    check("lat_t4_valid", 32'(ev_valid), 0);
    tick();
    check("lat_t5_valid", 32'(ev_valid), 1);
    check("lat_t5_ch", 32'(ev_ch), 3);
    check("idle_busy", 32'(busy), 1);
    exp_q.push_back(4'd3);
    repeat (2) tick();
    check("held_valid", 32'(ev_valid), 1);
    ev_ready = 1'b1;
    q_in = '0;
    repeat (4) tick();
    check("drain1_valid", 32'(ev_valid), 0);
    check("drain1_busy", 32'(busy), 0);

    // Round robin: last grant 5, then 1/5/6 together -> 6, 1, 5.
    q_in = 16'h0020;
    exp_q.push_back(4'd5);
    repeat (8) tick();
    q_in = '0;
    repeat (4) tick();
    q_in = 16'h0062;
    exp_q.push_back(4'd6);
    exp_q.push_back(4'd1);
    exp_q.push_back(4'd5);
    repeat (10) tick();
    q_in = '0;
    repeat (4) tick();
    check("rr_drained", 32'(exp_q.size()), 0);

    // Backpressure: 9 channels, depth 8 -> ch5 left pending.
    ev_ready = 1'b0;
    q_in = 16'h01FF;
    exp_q.push_back(4'd6); exp_q.push_back(4'd7); exp_q.push_back(4'd8);
    exp_q.push_back(4'd0); exp_q.push_back(4'd1); exp_q.push_back(4'd2);
    exp_q.push_back(4'd3); exp_q.push_back(4'd4); exp_q.push_back(4'd5);
    repeat (15) tick();
    check("bp_valid", 32'(ev_valid), 1);
    check("bp_head", 32'(ev_ch), 6);
    check("bp_ovf0", 32'(overflow), 0);
    q_in = '0;
    repeat (4) tick();
    q_in = 16'h0020;
    repeat (5) tick();
    check("bp_ovf1", 32'(overflow), 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_clr", 32'(overflow), 0);
    ev_ready = 1'b1;
    q_in = '0;
    repeat (20) tick();
    check("bp_drained", 32'(exp_q.size()), 0);
    check("bp_valid_end", 32'(ev_valid), 0);

    // Frame timing, then enable dropped mid-integrate of the third frame.
    enable = 1'b1;
    for (int n = 1; n <= 70; n++) begin
      tick();
      exp_low = (n <= 56) && (((n - 1) % 20) < 16);
      check($sformatf("spk_clk_%0d", n), 32'(spk_clk), 32'(!exp_low));
      if (n == 30) check("run_busy", 32'(busy), 1);
      if (n == 45) enable = 1'b0;
      if (n == 50) begin
        ev_ready = 1'b0;
        q_in = 16'h0004;
        exp_q.push_back(4'd2);
      end
      if (n == 65) check("idle_queued_busy", 32'(busy), 1);
    end
    ev_ready = 1'b1;
    q_in = '0;
    repeat (2) tick();
    check("idle_drained_busy", 32'(busy), 0);
    repeat (2) tick();

    // Reset with three queued events.
    ev_ready = 1'b0;
    q_in = 16'h0007;
    repeat (8) tick();
    check("pre_rst_valid", 32'(ev_valid), 1);
    rst_n = 1'b0;
    q_in = '0;
    #1;
    check("mid_rst_valid", 32'(ev_valid), 0);
    check("mid_rst_ch", 32'(ev_ch), 0);
    check("mid_rst_ovf", 32'(overflow), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_spk_clk", 32'(spk_clk), 1);
    tick();
    rst_n = 1'b1;
    ev_ready = 1'b1;
    repeat (12) tick();
    check("post_rst_valid", 32'(ev_valid), 0);
    check("final_queue", 32'(exp_q.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_scheduler.md
SPIKE_SCHEDULER -- requirements
Module: spike_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 8: number of spikifier channels served.
REQ-002 The block SHALL have parameter INT_CYCLES, default 16: clk cycles per integrate phase (minimum 1).
REQ-003 The block SHALL have parameter CMP_CYCLES, default 4: clk cycles per compare phase (minimum 3).
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 8: event FIFO entries (power of two).
REQ-005 The block SHALL have parameter TS_W, default 16: frame timestamp width.
REQ-006 The block SHALL have port clk  in  1  system clock; all state is updated on its rising edge.
REQ-007 The block SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-008 The block SHALL have port enable  in  1  run frames while high.
REQ-009 The block SHALL have port spk_clk  out  1  shared spikifier phase clock: 0 = integrate, 1 = compare/reset.
REQ-010 The block SHALL have port q_in  in  NUM_CH  spikifier outputs, asynchronous to clk.
REQ-011 The block SHALL have port ev_valid  out  1  event available.
REQ-012 The block SHALL have port ev_ready  in  1  consumer accepts the event.
REQ-013 The block SHALL have port ev_ch  out  $clog2(NUM_CH)  channel index of the event.
REQ-014 The block SHALL have port ev_ts  out  TS_W  frame number of the event; present only with SPK_TIMESTAMP_EN.
REQ-015 The block SHALL have port overflow  out  1  sticky lost-spike flag.
REQ-016 The block SHALL have port ovf_clr  in  1  clears overflow.
REQ-017 The block SHALL have port busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-018 The FSM SHALL have three states, IDLE, INTEGRATE and COMPARE, with a phase counter.
- spk_clk = 1 in IDLE and COMPARE; spk_clk = 0 in INTEGRATE.
- spk_clk is driven from a flop.
REQ-019 FSM transitions SHALL be:
- IDLE to INTEGRATE on the first edge with enable = 1.
- INTEGRATE to COMPARE after exactly INT_CYCLES cycles.
- COMPARE to INTEGRATE after exactly CMP_CYCLES cycles if enable = 1, otherwise COMPARE to IDLE.
REQ-020 Deasserting enable during INTEGRATE SHALL NOT abort the frame; the current COMPARE phase always completes.
REQ-021 The frame counter SHALL increment on each INTEGRATE-to-COMPARE transition and wrap modulo 2^TS_W.
REQ-022 Each q_in bit SHALL pass through a 2-flop synchronizer followed by a rising-edge detector; a detected rise sets pending[i].
REQ-023 Detection SHALL be accepted in every state; a rise is not gated by phase.
REQ-024 A rise on a channel whose pending bit is already set SHALL set overflow; the spike is dropped.
REQ-025 Each cycle in which the FIFO is not full, the round-robin arbiter SHALL grant one pending channel.
- Priority starts at the index after the last grant and wraps.
- The granted channel's pending bit clears and {ch, ts} is pushed.
REQ-026 When a channel is granted and newly rises in the same cycle, the new rise SHALL re-set its pending bit; no overflow is flagged.
REQ-027 The push latency, with FIFO empty and no other pending bits, SHALL be exact:
- q_in sampled high at edge t; pending set at t+3; pushed at t+4; ev_valid = 1 after t+4.
REQ-028 Handshake: an event transfers on an edge with ev_valid & ev_ready.
- ev_ch/ev_ts hold stable while ev_valid & !ev_ready.
- The next entry is presented the cycle after a transfer.
REQ-029 A push and a pop in the same cycle SHALL both succeed even when the FIFO is full.
REQ-030 While the FIFO is full, pending bits SHALL be held; they are not lost.
REQ-031 ovf_clr SHALL clear overflow; a simultaneous overflow event SHALL win (overflow stays 1).

Reset
REQ-032 While rst_n = 0, the block SHALL set:
- State IDLE, spk_clk = 1.
- ev_valid = 0, ev_ch = 0, ev_ts = 0.
- overflow = 0, busy = 0.
- FIFO empty, pending = 0, synchronizers = 0.
- Frame counter = 0, round-robin pointer = NUM_CH-1.
REQ-033 Reset asserted mid-frame SHALL drop all pending and queued events; no event is emitted after release until a new rise is detected.

Configuration
REQ-034 With macro SPK_TIMESTAMP_EN defined:
- Each FIFO entry stores the frame count at push time.
- ev_ts is presented.
REQ-035 Without SPK_TIMESTAMP_EN:
- The ev_ts port and the frame counter storage in the FIFO are absent.
- All other behaviour is identical.

Structure
REQ-036 Package spike_pkg SHALL hold the FSM state enum, the event struct {ch, ts} and the parameter defaults.
REQ-037 The FIFO SHALL be sub-module spike_fifo (synchronous, first-word-fall-through registered output, full/empty flags); arbitration and FSM SHALL stay in spike_scheduler.

Verification
REQ-038 Frame timing: INT_CYCLES=16, CMP_CYCLES=4, enable held -> spk_clk low 16 cycles, high 4 cycles, period 20; frame counter +1 per period.
REQ-039 Single spike: q_in[3] rises at edge t, FIFO empty -> ev_valid at t+5 with ev_ch=3; held until ev_ready.
REQ-040 Round robin: q_in[1], q_in[5] and q_in[6] rise together, last grant 5 -> events in order 6, 1, 5.
REQ-041 Backpressure: ev_ready=0, 9 spikes on distinct channels, FIFO_DEPTH=8 -> 8 queued, 1 pending, overflow=0; a second rise on the pending channel -> overflow=1.
REQ-042 Enable drop: enable falls mid-INTEGRATE -> frame finishes COMPARE then IDLE with spk_clk=1; busy falls after the FIFO drains.
REQ-043 Reset mid-operation: rst_n low with 3 queued events -> all outputs at reset values immediately, no events after release.
